paddle_ctrl_n: RTL

- Parametrised paddle position controller for the Pong top level; replaces per-source ad-hoc paddle logic.
- Drives NUM_PADDLES paddles. Each paddle has its own run-time input mode: hold, UART target, accelerometer tilt, or buttons.
- Positions update once per frame on frame_tick with rate limiting and clamping.
- Sits between the UART receiver, accelerometer SPI reader and key debouncers on one side, and the VGA renderer and game logic on the other.

---
 rtl/paddle_ctrl_n.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/paddle_ctrl_n.sv
// Paddle position controller: a UART two-byte target parser plus per-paddle frame
// update (hold / UART target / accelerometer tilt / buttons) with rate limit and clamp.
module paddle_ctrl_n #(
  parameter int NUM_PADDLES = 2,
  parameter int POS_W       = 10,
  parameter int POS_MIN     = 0,
  parameter int POS_MAX     = 420,
  parameter int INIT_POS    = 210,
  parameter int STEP_MAX    = 8,
  parameter int ACC_W       = 12,
  parameter int DEAD_ZONE   = 16,
  parameter int ACC_SHIFT   = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                         clk_50,
  input  logic                         reset,
  input  logic                         frame_tick,
  input  logic [2*NUM_PADDLES-1:0]     mode,
  input  logic [7:0]                   rx_byte,
  input  logic                         rx_dv,
  input  logic [ACC_W*NUM_PADDLES-1:0] accel,
  input  logic [NUM_PADDLES-1:0]       btn_up,
  input  logic [NUM_PADDLES-1:0]       btn_dn,
  output logic [POS_W*NUM_PADDLES-1:0] paddle_pos,
  output logic                         pos_valid,
  output logic                         cmd_err,
  output logic                         parser_state
);

  // Strobe semantics: rx_dv and frame_tick are single-cycle qualifiers that are
  // always consumed in the cycle they are high (no ready); pos_valid and cmd_err
  // are single-cycle pulses with no acknowledge.

  localparam int SW    = POS_W + 2;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic signed [SW-1:0] STEP_S = SW'(STEP_MAX);
  localparam logic signed [SW-1:0] MIN_S  = SW'(POS_MIN);
  localparam logic signed [SW-1:0] MAX_S  = SW'(POS_MAX);

  localparam logic [ACC_W-1:0] ACC_NEG_FULL = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] ACC_POS_FULL = {1'b0, {(ACC_W-1){1'b1}}};

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_DATA = 1'b1
  } parser_state_e;

  parser_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             err_d;
  logic             tgt_we;
  logic             hdr_ok;
  logic [SW-1:0]    tgt_scaled;
  logic [POS_W-1:0] tgt_wdata;
  logic [POS_W-1:0] target_q [NUM_PADDLES];

  assign hdr_ok = (rx_byte[7:2] == 6'b101000) && (32'(rx_byte[1:0]) < NUM_PADDLES);

  // Data byte scales to the full position range before clamping.
  assign tgt_scaled = SW'(rx_byte) << (POS_W - 8);
  assign tgt_wdata  = (tgt_scaled > SW'(POS_MAX)) ? POS_W'(POS_MAX) :
                      (tgt_scaled < SW'(POS_MIN)) ? POS_W'(POS_MIN) :
                      tgt_scaled[POS_W-1:0];

  assign parser_state = (state_q == ST_WAIT_DATA);

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      cmd_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      cmd_err <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    tgt_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_dv) begin
          if (hdr_ok) begin
            idx_d   = rx_byte[1:0];
            cnt_d   = '0;
            state_d = ST_WAIT_DATA;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_WAIT_DATA: begin
        // Any byte here is data, even one that looks like a header.
        if (rx_dv) begin
          tgt_we  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50) begin
    for (int i = 0; i < NUM_PADDLES; i++) begin
      if (reset) begin
        target_q[i] <= POS_W'(INIT_POS);
      end else if (tgt_we && (32'(idx_q) == i)) begin
        target_q[i] <= tgt_wdata;
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) pos_valid <= 1'b0;
    else       pos_valid <= frame_tick;
  end

  for (genvar g = 0; g < NUM_PADDLES; g++) begin : g_pad
    logic [POS_W-1:0]        pos_q;
    logic [POS_W-1:0]        pos_d;
    logic [1:0]              pad_mode;
    logic [ACC_W-1:0]        a_raw;
    logic [ACC_W-1:0]        a_mag;
    logic [ACC_W-1:0]        excess;
    logic signed [SW-1:0]    acc_mag;
    logic signed [SW-1:0]    pos_s;
    logic signed [SW-1:0]    tgt_s;
    logic signed [SW-1:0]    diff;
    logic signed [SW-1:0]    step;
    logic signed [SW-1:0]    sum;

    assign pad_mode = mode[2*g +: 2];
    assign a_raw    = accel[ACC_W*g +: ACC_W];

    always_comb begin
      pos_s   = $signed({2'b00, pos_q});
      tgt_s   = $signed({2'b00, target_q[g]});
      diff    = tgt_s - pos_s;
      excess  = '0;
      acc_mag = '0;
      step    = '0;

      // Most negative sample has no positive twin; saturate its magnitude.
      if (!a_raw[ACC_W-1])            a_mag = a_raw;
      else if (a_raw == ACC_NEG_FULL) a_mag = ACC_POS_FULL;
      else                            a_mag = ~a_raw + ACC_W'(1);

      if (32'(a_mag) > DEAD_ZONE) begin
        excess = (a_mag - ACC_W'(DEAD_ZONE)) >> ACC_SHIFT;
        if (excess == '0)                 acc_mag = SW'(1);
        else if (32'(excess) > STEP_MAX)  acc_mag = STEP_S;
        else                              acc_mag = SW'(excess);
      end

      case (pad_mode)
        2'b01: begin
          if (diff > STEP_S)        step = STEP_S;
          else if (diff < -STEP_S)  step = -STEP_S;
          else                      step = diff;
        end
        2'b10: step = a_raw[ACC_W-1] ? -acc_mag : acc_mag;
        2'b11: begin
          if (btn_up[g] && !btn_dn[g])      step = -STEP_S;
          else if (btn_dn[g] && !btn_up[g]) step = STEP_S;
        end
        default: step = '0;
      endcase

      // Clamp applies in every mode so an out-of-range position always recovers.
      sum = pos_s + step;
      if (sum < MIN_S)      pos_d = POS_W'(POS_MIN);
      else if (sum > MAX_S) pos_d = POS_W'(POS_MAX);
      else                  pos_d = sum[POS_W-1:0];
    end

    always_ff @(posedge clk_50) begin
      if (reset)           pos_q <= POS_W'(INIT_POS);
      else if (frame_tick) pos_q <= pos_d;
    end

    assign paddle_pos[POS_W*g +: POS_W] = pos_q;
  end

endmodule
